// File: rtl/fetch_queue.sv
// fetch_queue: instruction-byte prefetch queue.
//
// Streams bytes from sequential memory addresses into a small FIFO ahead of
// demand, so that the one-cycle memory read latency is hidden from the
// decode/execute sequencer. Each byte is tagged with its fetch address.
// A jump flushes everything (queued and in-flight) and redirects fetching.
//
// Parameters:
//   DEPTH     queue entries, power of two, 2..16
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          clock, all state updates on rising edge
//   reset        synchronous active-high reset
//   memAddr      read address to memory (the fetch pointer)
//   memStrobe    read request; memory returns data the following cycle
//   memDataRead  read data, valid the cycle after memStrobe
//   jumpValid    flush and redirect this cycle
//   jumpAddr     new fetch address, sampled with jumpValid
//   byteValid    head entry available
//   byteData     head byte
//   bytePc       address of byteData
//   byteReady    consumer accepts head when byteValid & byteReady
//   level        number of occupied queue entries
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward the returning
// memory byte straight to the outputs when the queue is empty, saving one
// cycle of latency after reset and after a jump.
module fetch_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [7:0]                 memAddr,
  output logic                       memStrobe,
  input  logic [7:0]                 memDataRead,
  input  logic                       jumpValid,
  input  logic [7:0]                 jumpAddr,
  output logic                       byteValid,
  output logic [7:0]                 byteData,
  output logic [7:0]                 bytePc,
  input  logic                       byteReady,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    fetchPcReg;
  logic          pendingReg;
  logic [7:0]    pendingPcReg;
  logic [PW-1:0] rdPtrReg;
  logic [PW-1:0] wrPtrReg;
  logic [LW-1:0] levelReg;

  logic [7:0] dataMem [DEPTH];
  logic [7:0] pcMem   [DEPTH];

  logic [LW:0] creditUsed;
  logic        fifoNotEmpty;
  logic        bypassTaken;
  logic        pushEn;
  logic        popEn;

  // The in-flight read already owns a slot, so it is counted against the
  // free space; a pop in the same cycle deliberately does not free credit,
  // which keeps memStrobe independent of byteReady.
  assign creditUsed   = {1'b0, levelReg} + {{LW{1'b0}}, pendingReg};
  assign memStrobe    = !reset && !jumpValid && (creditUsed < (LW+1)'(DEPTH));
  assign memAddr      = fetchPcReg;
  assign level        = levelReg;
  assign fifoNotEmpty = (levelReg != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypassActive;

  // Queue empty with a byte arriving: present it directly. If it is taken
  // this cycle it never enters the FIFO; otherwise it is written as usual.
  assign bypassActive = !fifoNotEmpty && pendingReg;
  assign bypassTaken  = bypassActive && byteReady;
  assign byteValid    = fifoNotEmpty || bypassActive;
  assign byteData     = bypassActive ? memDataRead  : dataMem[rdPtrReg];
  assign bytePc       = bypassActive ? pendingPcReg : pcMem[rdPtrReg];
`else
  assign bypassTaken  = 1'b0;
  assign byteValid    = fifoNotEmpty;
  assign byteData     = dataMem[rdPtrReg];
  assign bytePc       = pcMem[rdPtrReg];
`endif

  // Jump and reset outrank push and pop: the returning byte is discarded.
  assign pushEn = pendingReg && !bypassTaken && !jumpValid && !reset;
  assign popEn  = fifoNotEmpty && byteReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPcReg   <= RESET_PC;
      pendingReg   <= 1'b0;
      pendingPcReg <= RESET_PC;
      rdPtrReg     <= '0;
      wrPtrReg     <= '0;
      levelReg     <= '0;
    end else if (jumpValid) begin
      fetchPcReg   <= jumpAddr;
      pendingReg   <= 1'b0;
      rdPtrReg     <= '0;
      wrPtrReg     <= '0;
      levelReg     <= '0;
    end else begin
      if (memStrobe) begin
        fetchPcReg   <= fetchPcReg + 8'd1;
        pendingReg   <= 1'b1;
        pendingPcReg <= fetchPcReg;
      end else begin
        pendingReg   <= 1'b0;
      end

      if (pushEn) begin
        wrPtrReg <= wrPtrReg + 1'b1;
      end
      if (popEn) begin
        rdPtrReg <= rdPtrReg + 1'b1;
      end

      case ({pushEn, popEn})
        2'b10:   levelReg <= levelReg + 1'b1;
        2'b01:   levelReg <= levelReg - 1'b1;
        default: levelReg <= levelReg;
      endcase
    end
  end

  // Storage has no reset: contents are only observed while level > 0.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      dataMem[wrPtrReg] <= memDataRead;
      pcMem[wrPtrReg]   <= pendingPcReg;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
//
// A synchronous memory model returns memByte(addr) one cycle after a strobe.
// A cycle table checks byteValid/level/memStrobe/memAddr against hand-derived
// values; every accepted byte is checked against an expected-address stream
// that is restarted whenever the bench drives reset or a jump.
// Honours FETCH_QUEUE_BYPASS_EN when the bench is built with it.
module tb_fetch_queue;

  localparam int         DEPTH    = 4;
  localparam int         LW       = $clog2(DEPTH + 1);
  localparam logic [7:0] RESET_PC = 8'h00;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [7:0]    memAddr;
  logic          memStrobe;
  logic [7:0]    memDataRead;
  logic          jumpValid;
  logic [7:0]    jumpAddr;
  logic          byteValid;
  logic [7:0]    byteData;
  logic [7:0]    bytePc;
  logic          byteReady;
  logic [LW-1:0] level;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .memAddr    (memAddr),
    .memStrobe  (memStrobe),
    .memDataRead(memDataRead),
    .jumpValid  (jumpValid),
    .jumpAddr   (jumpAddr),
    .byteValid  (byteValid),
    .byteData   (byteData),
    .bytePc     (bytePc),
    .byteReady  (byteReady),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content differs from the address so pc/data swaps are visible.
  function automatic logic [7:0] memByte(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (memStrobe === 1'b1) memDataRead <= memByte(memAddr);
  end

  typedef struct {
    logic [7:0] pc;
    logic [7:0] data;
  } sbEntry_t;

  typedef struct {
    bit         rst;
    bit         jv;
    logic [7:0] ja;
    bit         rdy;
    bit         chk;
    bit         expValid;
    int         expLevel;
    bit         expStrobe;
    logic [7:0] expAddr;
  } vec_t;

  sbEntry_t expQ[$];
  vec_t     vecs[$];
  int       checks   = 0;
  int       failures = 0;
  int       popCount = 0;

  task automatic checkVal(input string name, input int idx,
                          input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic addVec(input bit rst, input bit jv, input logic [7:0] ja,
                        input bit rdy, input bit chk, input bit v, input int l,
                        input bit s, input logic [7:0] a);
    vec_t e;
    e.rst = rst; e.jv = jv; e.ja = ja; e.rdy = rdy; e.chk = chk;
    e.expValid = v; e.expLevel = l; e.expStrobe = s; e.expAddr = a;
    vecs.push_back(e);
  endtask

  task automatic restartStream(input logic [7:0] start);
    sbEntry_t e;
    expQ.delete();
    for (int i = 0; i < 128; i++) begin
      e.pc   = start + 8'(i);
      e.data = memByte(e.pc);
      expQ.push_back(e);
    end
  endtask

  // Apply inputs for one cycle and let combinational outputs settle.
  task automatic drive(input bit rst, input bit jv, input logic [7:0] ja, input bit rdy);
    @(negedge clk);
    reset     = rst;
    jumpValid = jv;
    jumpAddr  = ja;
    byteReady = rdy;
    #1;
  endtask

  // Score the handshake of the current cycle, then restart the expected
  // stream if this cycle flushes the queue.
  task automatic sbCycle(input bit rst, input bit jv, input logic [7:0] ja, input int idx);
    sbEntry_t e;
    if (byteValid === 1'b1 && byteReady) begin
      popCount++;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpectedByte[%0d] got pc=%0h want none", idx, bytePc);
      end else begin
        e = expQ.pop_front();
        checkVal("bytePc", idx, bytePc, e.pc);
        checkVal("byteData", idx, byteData, e.data);
      end
    end
    if (!$isunknown(level)) begin
      checkVal("levelBound", idx, (int'(level) <= DEPTH), 1);
`ifndef FETCH_QUEUE_BYPASS_EN
      checkVal("validVsLevel", idx, byteValid, (level != '0));
`endif
    end
    if (rst)      restartStream(RESET_PC);
    else if (jv)  restartStream(ja);
  endtask

  initial begin
    int  lat;
    bit  found;
    bit  j;
    bit  r;
    logic [7:0] a;

    reset = 1'b1; jumpValid = 1'b0; jumpAddr = 8'h00; byteReady = 1'b0;

    // rst jv ja rdy chk | valid level strobe addr
    addVec(1, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00);
    addVec(1, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00);
    // backpressure from reset
    addVec(0, 0, 8'h00, 0, 1,  0,   0, 1, 8'h00);
    addVec(0, 0, 8'h00, 0, 1,  BYP, 0, 1, 8'h01);
    addVec(0, 0, 8'h00, 0, 1,  1, 1, 1, 8'h02);
    addVec(0, 0, 8'h00, 0, 1,  1, 2, 1, 8'h03);
    addVec(0, 0, 8'h00, 0, 1,  1, 3, 0, 8'h04);
    addVec(0, 0, 8'h00, 0, 1,  1, 4, 0, 8'h04);
    addVec(0, 0, 8'h00, 0, 1,  1, 4, 0, 8'h04);
    // release: pop does not free credit in the same cycle
    addVec(0, 0, 8'h00, 1, 1,  1, 4, 0, 8'h04);
    addVec(0, 0, 8'h00, 1, 1,  1, 3, 1, 8'h04);
    addVec(0, 0, 8'h00, 1, 1,  1, 2, 1, 8'h05);
    addVec(0, 0, 8'h00, 1, 1,  1, 2, 1, 8'h06);
    addVec(0, 0, 8'h00, 1, 1,  1, 2, 1, 8'h07);
    // jump to 40 while streaming
    addVec(0, 1, 8'h40, 1, 1,  1,   2, 0, 8'h08);
    addVec(0, 0, 8'h00, 1, 1,  0,   0, 1, 8'h40);
    addVec(0, 0, 8'h00, 1, 1,  BYP, 0, 1, 8'h41);
    addVec(0, 0, 8'h00, 1, 1,  1, BYP ? 0 : 1, 1, 8'h42);
    addVec(0, 0, 8'h00, 1, 1,  1, BYP ? 0 : 1, 1, 8'h43);
    // jump to FE: fetch pointer wraps
    addVec(0, 1, 8'hFE, 1, 1,  1,   BYP ? 0 : 1, 0, 8'h44);
    addVec(0, 0, 8'h00, 1, 1,  0,   0, 1, 8'hFE);
    addVec(0, 0, 8'h00, 1, 1,  BYP, 0, 1, 8'hFF);
    addVec(0, 0, 8'h00, 1, 1,  1, BYP ? 0 : 1, 1, 8'h00);
    addVec(0, 0, 8'h00, 1, 1,  1, BYP ? 0 : 1, 1, 8'h01);
    addVec(0, 0, 8'h00, 1, 1,  1, BYP ? 0 : 1, 1, 8'h02);
    // fill the queue, then reset for one cycle
    addVec(0, 0, 8'h00, 0, 1,  1, BYP ? 0 : 1, 1, 8'h03);
    addVec(0, 0, 8'h00, 0, 1,  1, BYP ? 1 : 2, 1, 8'h04);
    addVec(0, 0, 8'h00, 0, 1,  1, BYP ? 2 : 3, BYP, 8'h05);
    addVec(0, 0, 8'h00, 0, 1,  1, BYP ? 3 : 4, 0, BYP ? 8'h06 : 8'h05);
    addVec(0, 0, 8'h00, 0, 1,  1, 4, 0, BYP ? 8'h06 : 8'h05);
    addVec(1, 0, 8'h00, 0, 1,  1, 4, 0, BYP ? 8'h06 : 8'h05);
    addVec(0, 0, 8'h00, 1, 1,  0,   0, 1, 8'h00);
    addVec(0, 0, 8'h00, 1, 1,  BYP, 0, 1, 8'h01);
    addVec(0, 0, 8'h00, 1, 1,  1, BYP ? 0 : 1, 1, 8'h02);
    addVec(0, 0, 8'h00, 1, 1,  1, BYP ? 0 : 1, 1, 8'h03);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].jv, vecs[i].ja, vecs[i].rdy);
      if (vecs[i].chk) begin
        checkVal("byteValid", i, byteValid, vecs[i].expValid);
        checkVal("level", i, level, vecs[i].expLevel);
        checkVal("memStrobe", i, memStrobe, vecs[i].expStrobe);
        checkVal("memAddr", i, memAddr, vecs[i].expAddr);
      end
      sbCycle(vecs[i].rst, vecs[i].jv, vecs[i].ja, i);
    end

    // Jump-to-first-byte latency, bounded wait.
    drive(0, 1, 8'h80, 1);
    sbCycle(0, 1, 8'h80, 100);
    lat = 0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 8'h00, 1);
      if (byteValid === 1'b1 && !found) begin
        found = 1'b1;
        lat = k;
      end
      sbCycle(0, 0, 8'h00, 100 + k);
    end
    checkVal("jumpLatency", 0, lat, BYP ? 2 : 3);

    // Random backpressure with periodic jumps; every byte scored.
    popCount = 0;
    for (int c = 0; c < 400; c++) begin
      j = (c % 50 == 49);
      a = 8'($urandom_range(0, 255));
      r = ($urandom_range(0, 3) != 0);
      drive(0, j, a, r);
      sbCycle(0, j, a, 200 + c);
    end
    checkVal("popsSeen", 0, (popCount > 150), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
